mxseu_sequencer: RTL and testbench

//   Instruction sequencer for the MX11 SEU datapath (ISA ROM + mx11seu).
//   - Buffers 8-bit instruction bytes from an upstream source in a small FIFO.
//   - Issues each byte to the SEU with the fetch / ce_n timing that the ISA ROM
//     and the execution unit require.
//   - Spaces instructions by a fixed execute window and counts retirements and

---
 rtl/mxseu_pkg.sv | 13 +
 rtl/mxseu_insr_fifo.sv | 53 +++++
 rtl/mxseu_sequencer.sv | 111 +++++++++++
 tb/tb_mxseu_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxseu_pkg.sv
// Shared types for the MX11 SEU instruction sequencer.
package mxseu_pkg;

  typedef logic [7:0] insr_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    WRITE
  } seq_state_t;

endpackage

// File: rtl/mxseu_insr_fifo.sv
// Instruction-byte FIFO: registered full/empty, combinational head read, no fall-through.
module mxseu_insr_fifo
  import mxseu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  insr_t din,
  input  logic  pop,
  output insr_t dout,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  insr_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/mxseu_sequencer.sv
// Issues buffered instruction bytes to the MX11 SEU with fetch/ce_n timing,
// a fixed execute window, and retire / write-back counters.
module mxseu_sequencer
  import mxseu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_insr,
  output logic             in_ready,
  input  logic             halt,
  output logic             fetch,
  output logic [7:0]       insr,
  output logic             ce_n,
  input  logic             load_en,
  output logic             busy,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] wb_count
);

  localparam int unsigned XW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [XW-1:0]    r_xcnt;
  logic             r_fetch;
  insr_t            r_insr;
  logic             r_ce_n;
  logic             r_busy;
  logic             r_retire;
  logic [CNT_W-1:0] r_retire_count;
  logic [CNT_W-1:0] r_wb_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  insr_t            w_head;

  assign in_ready     = ~w_full;
  assign w_push       = in_valid & ~w_full;
  assign w_issue      = ~w_empty & ~halt;
  assign w_pop        = (w_next == FETCH);
  assign fetch        = r_fetch;
  assign insr         = r_insr;
  assign ce_n         = r_ce_n;
  assign busy         = r_busy;
  assign retire       = r_retire;
  assign retire_count = r_retire_count;
  assign wb_count     = r_wb_count;

  mxseu_insr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (in_insr),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_next = FETCH;
      FETCH:   w_next = EXEC;
      EXEC:    if (r_xcnt == '0) w_next = WRITE;
      WRITE:   w_next = w_issue ? FETCH : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_xcnt         <= '0;
      r_fetch        <= 1'b0;
      r_insr         <= '0;
      r_ce_n         <= 1'b1;
      r_busy         <= 1'b0;
      r_retire       <= 1'b0;
      r_retire_count <= '0;
      r_wb_count     <= '0;
    end else begin
      r_state  <= w_next;
      r_fetch  <= (w_next == FETCH);
      r_ce_n   <= (w_next == IDLE);
      r_busy   <= (w_next != IDLE);
      r_retire <= (w_next == WRITE);
      if (w_pop) r_insr <= w_head;
      if (r_state == FETCH)
        r_xcnt <= XW'(EXEC_CYCLES - 1);
      else if ((r_state == EXEC) && (r_xcnt != '0))
        r_xcnt <= r_xcnt - 1'b1;
      if (r_state == WRITE) begin
        r_retire_count <= r_retire_count + 1'b1;
        if (load_en) r_wb_count <= r_wb_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mxseu_sequencer.sv
// Self-checking bench for mxseu_sequencer against a queue-based issue/retire model.
module tb_mxseu_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned EXECC = 1;
  // Narrow counters so wrap-around is reachable in a short run.
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_insr = 8'h00;
  logic             halt = 1'b0;
  logic             load_en = 1'b0;
  logic             in_ready, fetch, ce_n, busy, retire;
  logic [7:0]       insr;
  logic [CNT_W-1:0] retire_count, wb_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_acc = 0;
  int m_fet = 0;
  logic [CNT_W-1:0] m_ret = '0;
  logic [CNT_W-1:0] m_wb = '0;
  logic st_write = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int fcyc_q[$];

  mxseu_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .EXEC_CYCLES (EXECC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_insr      (in_insr),
    .in_ready     (in_ready),
    .halt         (halt),
    .fetch        (fetch),
    .insr         (insr),
    .ce_n         (ce_n),
    .load_en      (load_en),
    .busy         (busy),
    .retire       (retire),
    .retire_count (retire_count),
    .wb_count     (wb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic reset_model();
    m_acc = 0; m_fet = 0; m_ret = '0; m_wb = '0; st_write = 1'b0;
    exp_q.delete(); got_q.delete(); fcyc_q.delete();
  endtask

  // One clock: update the model for this edge, then observe 1 time unit after it.
  task automatic tick();
    if (st_write) begin
      m_ret = m_ret + 1'b1;
      if (load_en) m_wb = m_wb + 1'b1;
    end
    if (in_valid && ((m_acc - m_fet) < DEPTH)) begin
      m_acc++;
      exp_q.push_back(in_insr);
    end
    @(posedge clk); #1;
    cyc++;
    st_write = retire;
    if (fetch) begin
      got_q.push_back(insr);
      fcyc_q.push_back(cyc);
      m_fet++;
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    halt = 1'b0;
    while ((busy || (m_acc != m_fet) || st_write) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: busy=%0b queued=%0d, required idle within 200 cycles", busy, m_acc - m_fet);
    end
    got_q.delete(); exp_q.delete(); fcyc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({fetch, ce_n, busy, retire, in_ready} !== 5'b01001) begin
      errors++;
      $display("FAIL reset_ctrl: {fetch,ce_n,busy,retire,in_ready}=%b required 01001", {fetch, ce_n, busy, retire, in_ready});
    end
    checks++;
    if (insr !== 8'h00) begin errors++; $display("FAIL reset_insr: got %h required 00", insr); end
    checks++;
    if (retire_count !== '0 || wb_count !== '0) begin
      errors++; $display("FAIL reset_counts: retire=%0d wb=%0d required 0 0", retire_count, wb_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_insr = 8'h3A;
    tick();
    in_valid = 1'b0;
    checks++;
    if (fetch !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_nofallthrough: fetch=%b busy=%b required 0 0", fetch, busy);
    end
    tick();
    checks++;
    if (fetch !== 1'b1 || insr !== 8'h3A || ce_n !== 1'b0) begin
      errors++; $display("FAIL single_fetch: fetch=%b insr=%h ce_n=%b required 1 3a 0", fetch, insr, ce_n);
    end
    tick();
    checks++;
    if (fetch !== 1'b0 || ce_n !== 1'b0 || retire !== 1'b0) begin
      errors++; $display("FAIL single_exec: fetch=%b ce_n=%b retire=%b required 0 0 0", fetch, ce_n, retire);
    end
    tick();
    checks++;
    if (retire !== 1'b1 || ce_n !== 1'b0) begin
      errors++; $display("FAIL single_write: retire=%b ce_n=%b required 1 0", retire, ce_n);
    end
    tick();
    checks++;
    if (retire !== 1'b0 || busy !== 1'b0 || ce_n !== 1'b1 || retire_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL single_idle: retire=%b busy=%b ce_n=%b retire_count=%0d required 0 0 1 1", retire, busy, ce_n, retire_count);
    end
    tick(); tick();
    checks++;
    if (insr !== 8'h3A) begin errors++; $display("FAIL single_insr_hold: got %h required 3a", insr); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3];
    logic [CNT_W-1:0] exp_rc;
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
    exp_rc = m_ret + CNT_W'(3);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_insr = b[i];
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && (busy || st_write); i++) tick();
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL b2b_count: fetches=%0d required 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== b[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %h required %h", i, got_q[i], b[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (fcyc_q[i] - fcyc_q[i-1] != int'(EXECC + 2)) begin
          errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d", i, fcyc_q[i] - fcyc_q[i-1], EXECC + 2);
        end
      end
    end
    checks++;
    if (retire_count !== exp_rc) begin
      errors++; $display("FAIL b2b_retire_count: got %0d required %0d", retire_count, exp_rc);
    end
    drain();
  endtask

  task automatic test_full();
    logic [CNT_W-1:0] exp_rc;
    exp_rc = m_ret + CNT_W'(4);
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_insr = 8'hA0 + 8'(i);
      checks++;
      if (in_ready !== (i < 4)) begin
        errors++; $display("FAIL full_ready[%0d]: got %b required %b", i, in_ready, (i < 4));
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || got_q.size() != 0) begin
      errors++; $display("FAIL full_hold: in_ready=%b fetches=%0d required 0 0", in_ready, got_q.size());
    end
    halt = 1'b0;
    for (int i = 0; i < 40 && (m_acc != m_fet || busy || st_write); i++) tick();
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL full_retired: fetches=%0d required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== 8'hA0 + 8'(i)) begin
          errors++; $display("FAIL full_order[%0d]: got %h required %h", i, got_q[i], 8'hA0 + 8'(i));
        end
      end
    end
    checks++;
    if (retire_count !== exp_rc) begin
      errors++; $display("FAIL full_retire_count: got %0d required %0d", retire_count, exp_rc);
    end
    drain();
  endtask

  task automatic test_halt_mid();
    in_valid = 1'b1; in_insr = 8'h5C; tick();
    in_insr = 8'hC5; tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (fetch !== 1'b0 || ce_n !== 1'b0) begin
      errors++; $display("FAIL halt_exec: fetch=%b ce_n=%b required 0 0", fetch, ce_n);
    end
    halt = 1'b1;
    tick();
    checks++;
    if (retire !== 1'b1) begin errors++; $display("FAIL halt_write: retire=%b required 1", retire); end
    tick(); tick(); tick(); tick();
    checks++;
    if (busy !== 1'b0 || got_q.size() != 1) begin
      errors++; $display("FAIL halt_stopped: busy=%b fetches=%0d required 0 1", busy, got_q.size());
    end
    halt = 1'b0;
    tick();
    checks++;
    if (fetch !== 1'b1 || insr !== 8'hC5) begin
      errors++; $display("FAIL halt_resume: fetch=%b insr=%h required 1 c5", fetch, insr);
    end
    drain();
  endtask

  task automatic test_wb();
    logic [2:0] pat;
    logic [CNT_W-1:0] exp_rc, exp_wc;
    int k = 0;
    pat = 3'b101;
    exp_rc = m_ret + CNT_W'(3);
    exp_wc = m_wb + CNT_W'(2);
    for (int t = 0; t < 40 && !(k == 3 && !st_write); t++) begin
      in_valid = (t < 3);
      in_insr = 8'($urandom);
      tick();
      load_en = 1'b0;
      if (retire && k < 3) begin
        load_en = pat[k];
        k++;
      end
    end
    load_en = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (retire_count !== exp_rc || wb_count !== exp_wc) begin
      errors++;
      $display("FAIL wb_counts: retire=%0d wb=%0d required %0d %0d", retire_count, wb_count, exp_rc, exp_wc);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int rets = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_insr = 8'hE0 + 8'(i); tick();
    end
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({fetch, ce_n, busy, retire, in_ready} !== 5'b01001 || insr !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_ctrl: {fetch,ce_n,busy,retire,in_ready}=%b insr=%h required 01001 00", {fetch, ce_n, busy, retire, in_ready}, insr);
    end
    checks++;
    if (retire_count !== '0 || wb_count !== '0) begin
      errors++; $display("FAIL rstmid_counts: retire=%0d wb=%0d required 0 0", retire_count, wb_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (retire) rets++;
    end
    checks++;
    if (got_q.size() != 0 || rets != 0) begin
      errors++; $display("FAIL rstmid_discard: fetches=%0d retires=%0d required 0 0", got_q.size(), rets);
    end
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] all1;
    all1 = '1;
    load_en = 1'b1;
    for (int t = 0; t < 200 && m_acc < (1 << CNT_W) - 1; t++) begin
      in_valid = 1'b1; in_insr = 8'($urandom); tick();
    end
    drain();
    checks++;
    if (retire_count !== all1 || wb_count !== all1) begin
      errors++; $display("FAIL wrap_allones: retire=%0d wb=%0d required %0d %0d", retire_count, wb_count, all1, all1);
    end
    in_valid = 1'b1; in_insr = 8'h77; tick();
    drain();
    checks++;
    if (retire_count !== '0 || wb_count !== '0) begin
      errors++; $display("FAIL wrap_zero: retire=%0d wb=%0d required 0 0", retire_count, wb_count);
    end
    load_en = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 300; t++) begin
      in_valid = ($urandom % 3) != 0;
      in_insr = 8'($urandom);
      halt = ($urandom % 8) == 0;
      load_en = 1'($urandom);
      checks++;
      if (in_ready !== ((m_acc - m_fet) < DEPTH)) begin
        errors++; $display("FAIL rand_ready@%0d: got %b required %b", cyc, in_ready, ((m_acc - m_fet) < DEPTH));
      end
      tick();
    end
    in_valid = 1'b0; halt = 1'b0;
    for (int i = 0; i < 100 && (m_acc != m_fet || busy || st_write); i++) tick();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_issued: fetches=%0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_order[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (retire_count !== m_ret || wb_count !== m_wb) begin
      errors++; $display("FAIL rand_counts: retire=%0d wb=%0d required %0d %0d", retire_count, wb_count, m_ret, m_wb);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_halt_mid();
    test_wb();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
